// File: rtl/tblink_rpc_run_ctrl.sv
// Run-window controller: accepts "run N cycles" requests, holds run_en high for exactly N cycles
// (or until abort), then presents a completion response carrying the accumulated run-time counter.
module tblink_rpc_run_ctrl #(
    parameter int CNT_W  = 32,
    parameter int TIME_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CNT_W-1:0]  req_cycles,
    input  logic              abort,
    output logic              run_en,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TIME_W-1:0] rsp_time,
    output logic              rsp_aborted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_remaining;
    logic [CNT_W-1:0]    w_remaining_nxt;
    logic [TIME_W-1:0]   r_time;
    logic [TIME_W-1:0]   w_time_nxt;
    logic [TIME_W-1:0]   r_rsp_time;
    logic [TIME_W-1:0]   w_rsp_time_nxt;
    logic                r_rsp_aborted;
    logic                w_rsp_aborted_nxt;
    logic                r_req_ready;
    logic                r_run_en;
    logic                r_rsp_valid;

    always_comb begin
        w_state_nxt       = r_state;
        w_remaining_nxt   = r_remaining;
        w_time_nxt        = r_time;
        w_rsp_time_nxt    = r_rsp_time;
        w_rsp_aborted_nxt = r_rsp_aborted;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_req_ready) begin
                    w_remaining_nxt = req_cycles;
                    if (req_cycles == '0) begin
                        w_state_nxt       = ST_RESP;
                        w_rsp_time_nxt    = r_time;
                        w_rsp_aborted_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_remaining_nxt = r_remaining - CNT_W'(1);
                w_time_nxt      = r_time + TIME_W'(1);
                // The final counted cycle wins over a coincident abort.
                if (r_remaining == CNT_W'(1)) begin
                    w_state_nxt       = ST_RESP;
                    w_rsp_time_nxt    = r_time + TIME_W'(1);
                    w_rsp_aborted_nxt = 1'b0;
                end else if (abort) begin
                    w_state_nxt       = ST_RESP;
                    w_rsp_time_nxt    = r_time + TIME_W'(1);
                    w_rsp_aborted_nxt = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_time        <= '0;
            r_rsp_time    <= '0;
            r_rsp_aborted <= 1'b0;
            r_req_ready   <= 1'b1;
            r_run_en      <= 1'b0;
            r_rsp_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_remaining   <= w_remaining_nxt;
            r_time        <= w_time_nxt;
            r_rsp_time    <= w_rsp_time_nxt;
            r_rsp_aborted <= w_rsp_aborted_nxt;
            // Status outputs are registered copies of the next-state decode.
            r_req_ready   <= (w_state_nxt == ST_IDLE);
            r_run_en      <= (w_state_nxt == ST_RUN);
            r_rsp_valid   <= (w_state_nxt == ST_RESP);
        end
    end

    assign req_ready   = r_req_ready;
    assign run_en      = r_run_en;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_time    = r_rsp_time;
    assign rsp_aborted = r_rsp_aborted;

endmodule

// File: tb/tb_tblink_rpc_run_ctrl.sv
// Bench for tblink_rpc_run_ctrl: a 64-bit and a 4-bit time-counter instance share stimulus and
// are both checked against a transaction-level model of run length, abort outcome and time.
module tb_tblink_rpc_run_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [31:0] req_cycles;
    logic        abort;
    logic        rsp_ready;

    logic        req_ready,   run_en,   rsp_valid,   rsp_aborted;
    logic [63:0] rsp_time;
    logic        req_ready_s, run_en_s, rsp_valid_s, rsp_aborted_s;
    logic [3:0]  rsp_time_s;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] m_time;

    always #5 clock = ~clock;

    tblink_rpc_run_ctrl #(.CNT_W(32), .TIME_W(64)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_cycles(req_cycles), .abort(abort), .run_en(run_en), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_time(rsp_time), .rsp_aborted(rsp_aborted)
    );

    tblink_rpc_run_ctrl #(.CNT_W(32), .TIME_W(4)) dut_s (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_s),
        .req_cycles(req_cycles), .abort(abort), .run_en(run_en_s), .rsp_valid(rsp_valid_s),
        .rsp_ready(rsp_ready), .rsp_time(rsp_time_s), .rsp_aborted(rsp_aborted_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic rr, input logic re, input logic rv);
        chk({tag, ".ctl"},   64'({req_ready, run_en, rsp_valid}),       64'({rr, re, rv}));
        chk({tag, ".ctl_s"}, 64'({req_ready_s, run_en_s, rsp_valid_s}), 64'({rr, re, rv}));
    endtask

    // One request/response transaction. abort_at = run cycle (1-based) carrying abort, 0 = none.
    // hold = cycles rsp_ready stays low; keep_req holds req_valid with next_n during the response.
    task automatic run_txn(input int unsigned n, input int unsigned abort_at, input int hold,
                           input bit keep_req, input int unsigned next_n);
        bit          exp_abt;
        int unsigned runs;
        exp_abt = (abort_at != 0) && (abort_at < n);
        runs    = exp_abt ? abort_at : n;

        chk_ctl("idle", 1'b1, 1'b0, 1'b0);
        req_valid  = 1'b1;
        req_cycles = n;
        abort      = 1'($urandom_range(0, 1));
        tick();
        req_valid  = 1'b0;
        abort      = 1'b0;

        for (int k = 1; k <= int'(runs); k++) begin
            chk_ctl("run", 1'b0, 1'b1, 1'b0);
            abort = (k == int'(abort_at));
            tick();
        end
        abort  = 1'b0;
        m_time = m_time + 64'(runs);

        for (int h = 0; h <= hold; h++) begin
            chk_ctl("resp", 1'b0, 1'b0, 1'b1);
            chk("rsp_time",      rsp_time,              m_time);
            chk("rsp_time_s",    64'(rsp_time_s),       64'(m_time[3:0]));
            chk("rsp_aborted",   64'({rsp_aborted, rsp_aborted_s}), 64'({exp_abt, exp_abt}));
            rsp_ready = (h == hold);
            abort     = 1'($urandom_range(0, 1));
            if (keep_req) begin
                req_valid  = 1'b1;
                req_cycles = next_n;
            end
            tick();
        end
        rsp_ready = 1'b0;
        abort     = 1'b0;
        chk_ctl("done", 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_cycles = '0;
        abort      = 1'b0;
        rsp_ready  = 1'b0;
        m_time     = '0;
        tick();
        tick();
        chk_ctl("reset", 1'b1, 1'b0, 1'b0);
        chk("reset.rsp_time", rsp_time, 64'd0);
        chk("reset.rsp_aborted", 64'({rsp_aborted, rsp_aborted_s}), 64'd0);
        reset = 1'b0;
        tick();

        run_txn(5, 0, 0, 1'b0, 0);
        run_txn(3, 0, 0, 1'b0, 0);
        run_txn(0, 0, 0, 1'b0, 0);
        run_txn(100, 4, 0, 1'b0, 0);
        run_txn(6, 6, 0, 1'b0, 0);
        run_txn(2, 0, 10, 1'b1, 7);
        run_txn(7, 0, 0, 1'b0, 0);

        for (int t = 0; t < 10; t++) begin
            int unsigned n;
            int unsigned ab;
            n  = $urandom_range(0, 30);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, n + 2) : 0;
            run_txn(n, ab, int'($urandom_range(0, 3)), 1'b0, 0);
        end

        // Reset landing on the third run cycle of a 10-cycle window.
        req_valid  = 1'b1;
        req_cycles = 10;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk_ctl("pre_rst", 1'b0, 1'b1, 1'b0);
        reset = 1'b1;
        tick();
        chk_ctl("mid_rst", 1'b1, 1'b0, 1'b0);
        chk("mid_rst.rsp_time", rsp_time, 64'd0);
        chk("mid_rst.rsp_time_s", 64'(rsp_time_s), 64'd0);
        reset  = 1'b0;
        m_time = '0;
        tick();
        run_txn(20, 0, 0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
